// File: rtl/fixed_point_pkg.sv
// Shared types and sizing helpers for the fixed-point MAC datapath.
// Q-format bounds are derived from the total signed operand width.
package fixed_point_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    function automatic int acc_width(input int width, input int lanes, input int acc_guard);
        return 2 * width + acc_guard + $clog2(lanes);
    endfunction

    function automatic longint q_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint q_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fixed_point_round_sat.sv
// Rescales a wide accumulator back to Q format with truncate or round-half-up,
// then either clamps or wraps into WIDTH bits while flagging overflow.
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int WIDTH      = 17,
    parameter int FRAC_WIDTH = 8,
    parameter int ACC_W      = 42
) (
    input  logic signed [ACC_W-1:0] acc,
    input  round_mode_e             round,
    input  logic                    sat,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow
);

    // One extra bit so the rounding increment can never wrap the accumulator value.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) <<< (FRAC_WIDTH - 1);
    localparam logic signed [WIDTH-1:0] QMAX = WIDTH'(q_max(WIDTH));
    localparam logic signed [WIDTH-1:0] QMIN = WIDTH'(q_min(WIDTH));

    function automatic logic signed [EXT_W-1:0] rescale(input logic signed [ACC_W-1:0] a,
                                                       input round_mode_e          mode);
        logic signed [EXT_W-1:0] ext;
        ext = {a[ACC_W-1], a};
        if (mode == RND_HALF_UP)
            ext = ext + HALF;
        return ext >>> FRAC_WIDTH;
    endfunction

    function automatic logic out_of_range(input logic signed [EXT_W-1:0] t);
        return t[EXT_W-1:WIDTH-1] != {(EXT_W - WIDTH + 1){t[WIDTH-1]}};
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [EXT_W-1:0] t,
                                                        input logic                    en,
                                                        input logic                    ovf);
        if (en && ovf)
            return t[EXT_W-1] ? QMIN : QMAX;
        return t[WIDTH-1:0];
    endfunction

    logic signed [EXT_W-1:0] tmp;

    always_comb begin
        tmp      = rescale(acc, round);
        overflow = out_of_range(tmp);
        result   = saturate(tmp, sat, overflow);
    end

endmodule

// File: rtl/fixed_point_mac.sv
// Pipelined multi-lane fixed-point dot-product engine: multiply, accumulate,
// then rescale/round/saturate one result per vector, with a global stall.
module fixed_point_mac
    import fixed_point_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
    parameter int LANES      = 1,
    parameter int ACC_GUARD  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*WIDTH-1:0]  in_a,
    input  logic [LANES*WIDTH-1:0]  in_b,
    input  logic                    in_last,
    input  logic                    in_round,
    input  logic                    in_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_result,
    output logic                    out_overflow
);

    localparam int ACC_W  = acc_width(WIDTH, LANES, ACC_GUARD);
    localparam int PROD_W = 2 * WIDTH;

    logic                     advance;
    logic signed [PROD_W-1:0] prod_c  [LANES];
    logic signed [PROD_W-1:0] prod_p0 [LANES];
    logic                     vld_p0, last_p0, sat_p0;
    round_mode_e              round_p0;
    logic signed [ACC_W-1:0]  lane_sum_c, acc_p1;
    logic                     vld_p1, first_p1, last_p1, sat_p1;
    round_mode_e              round_p1;
    logic signed [WIDTH-1:0]  result_c;
    logic                     overflow_c;

    // A held result freezes the entire pipeline, so nothing upstream may move.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            prod_c[i] = $signed(in_a[i*WIDTH +: WIDTH]) * $signed(in_b[i*WIDTH +: WIDTH]);
    end

    always_comb begin
        lane_sum_c = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum_c = lane_sum_c + ACC_W'(prod_c_ext(prod_p0[i]));
    end

    function automatic logic signed [ACC_W-1:0] prod_c_ext(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Stage 1: full-precision lane products and beat attributes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            last_p0  <= 1'b0;
            round_p0 <= RND_TRUNC;
            sat_p0   <= 1'b0;
        end else if (advance) begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                last_p0  <= in_last;
                round_p0 <= round_mode_e'(in_round);
                sat_p0   <= in_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance && in_valid)
            prod_p0 <= prod_c;
    end

    // Stage 2: lane reduction and accumulation; first beat of a vector reloads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b1;
            acc_p1   <= '0;
            last_p1  <= 1'b0;
            round_p1 <= RND_TRUNC;
            sat_p1   <= 1'b0;
        end else if (advance) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                acc_p1   <= first_p1 ? lane_sum_c : acc_p1 + lane_sum_c;
                first_p1 <= last_p0;
                last_p1  <= last_p0;
                round_p1 <= round_p0;
                sat_p1   <= sat_p0;
            end
        end
    end

    fixed_point_round_sat #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ACC_W      (ACC_W)
    ) u_round_sat (
        .acc      (acc_p1),
        .round    (round_p1),
        .sat      (sat_p1),
        .result   (result_c),
        .overflow (overflow_c)
    );

    // Stage 3: result register, loaded on last beats only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
        end else if (advance) begin
            if (vld_p1 && last_p1) begin
                out_valid    <= 1'b1;
                out_result   <= result_c;
                out_overflow <= overflow_c;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Directed bench for fixed_point_mac: single-lane table vectors plus hand-written
// multi-beat, backpressure and 4-lane reset sequences.
module tb_fixed_point_mac;

    localparam int W = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, in_valid, in_ready, in_last, in_round, in_sat;
    logic                out_valid, out_ready, out_overflow;
    logic [W-1:0]        in_a, in_b;
    logic signed [W-1:0] out_result;

    logic                rst4, in_valid4, in_ready4, in_last4, in_round4, in_sat4;
    logic                out_valid4, out_ready4, out_overflow4;
    logic [4*W-1:0]      in_a4, in_b4;
    logic signed [W-1:0] out_result4;

    int n_cmp = 0;
    int n_bad = 0;

    fixed_point_mac #(.LANES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_round(in_round), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow)
    );

    fixed_point_mac #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_last(in_last4), .in_round(in_round4), .in_sat(in_sat4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_result(out_result4), .out_overflow(out_overflow4)
    );

    typedef struct {
        string name;
        int    a;
        int    b;
        logic  rnd;
        logic  sat;
        int    exp_r;
        logic  exp_o;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic push(input int a, input int b, input logic last, input logic rnd, input logic sat);
        logic took;
        in_valid = 1'b1;
        in_a = W'(a);
        in_b = W'(b);
        in_last = last;
        in_round = rnd;
        in_sat = sat;
        for (int i = 0; i < 50; i++) begin
            took = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (took) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL push: in_ready=%0b for 50 cycles, required 1", in_ready);
    endtask

    task automatic push4(input int a, input int b, input logic last);
        logic [W-1:0] la, lb;
        logic took;
        la = W'(a);
        lb = W'(b);
        in_valid4 = 1'b1;
        in_a4 = {4{la}};
        in_b4 = {4{lb}};
        in_last4 = last;
        for (int i = 0; i < 50; i++) begin
            took = in_ready4;
            @(posedge clk);
            @(negedge clk);
            if (took) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL push4: in_ready=%0b for 50 cycles, required 1", in_ready4);
    endtask

    task automatic wait_out(input string name, output logic signed [W-1:0] r, output logic ovf,
                            output int cyc);
        r = '0;
        ovf = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                r = out_result;
                ovf = out_overflow;
                cyc = i;
                return;
            end
        end
        cyc = -1;
        n_cmp++;
        n_bad++;
        $display("FAIL %s: out_valid=0 for 30 cycles, required 1", name);
    endtask

    task automatic wait_out4(input string name, output logic signed [W-1:0] r);
        r = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid4 === 1'b1) begin
                r = out_result4;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: out_valid=0 for 30 cycles, required 1", name);
    endtask

    initial begin
        logic signed [W-1:0] r;
        logic ovf;
        int cyc;

        tbl[0] = '{"mul_1p5x2",  384,    512,   1'b0, 1'b0, 768,    1'b0};
        tbl[1] = '{"trunc_pos",  1,      128,   1'b0, 1'b0, 0,      1'b0};
        tbl[2] = '{"round_pos",  1,      128,   1'b1, 1'b0, 1,      1'b0};
        tbl[3] = '{"trunc_neg",  -1,     128,   1'b0, 1'b0, -1,     1'b0};
        tbl[4] = '{"round_neg",  -1,     128,   1'b1, 1'b0, 0,      1'b0};
        tbl[5] = '{"sat_pos",    32512,  32512, 1'b0, 1'b1, 65535,  1'b1};
        tbl[6] = '{"wrap_pos",   32512,  32512, 1'b0, 1'b0, -65280, 1'b1};
        tbl[7] = '{"sat_neg",    -32512, 32512, 1'b0, 1'b1, -65536, 1'b1};
        tbl[8] = '{"max_fit",    65535,  256,   1'b0, 1'b1, 65535,  1'b0};
        tbl[9] = '{"min_fit",    -65536, 256,   1'b1, 1'b1, -65536, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        in_round = 1'b0; in_sat = 1'b0; out_ready = 1'b1;
        rst4 = 1'b1; in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_last4 = 1'b0;
        in_round4 = 1'b0; in_sat4 = 1'b0; out_ready4 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_result", out_result, 0);
        check("rst.out_overflow", out_overflow, 0);
        rst = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            push(tbl[i].a, tbl[i].b, 1'b1, tbl[i].rnd, tbl[i].sat);
            in_valid = 1'b0;
            wait_out(tbl[i].name, r, ovf, cyc);
            check($sformatf("%s.result", tbl[i].name), r, tbl[i].exp_r);
            check($sformatf("%s.overflow", tbl[i].name), ovf, tbl[i].exp_o);
            check($sformatf("%s.latency", tbl[i].name), cyc, 2);
            @(negedge clk);
            check($sformatf("%s.valid_clear", tbl[i].name), out_valid, 0);
        end

        // two-beat vector followed immediately by a one-beat vector
        push(384, 512, 1'b0, 1'b1, 1'b1);
        push(512, -128, 1'b1, 1'b0, 1'b0);
        push(256, 256, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_out("two_beat", r, ovf, cyc);
        check("two_beat.result", r, 512);
        check("two_beat.overflow", ovf, 0);
        wait_out("follow_on", r, ovf, cyc);
        check("follow_on.result", r, 256);
        check("follow_on.latency", cyc, 1);

        // backpressure: three results queued behind a stalled consumer
        @(negedge clk);
        out_ready = 1'b0;
        push(256, 256, 1'b1, 1'b0, 1'b0);
        push(512, 256, 1'b1, 1'b0, 1'b0);
        push(768, 256, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", out_valid, 1);
            check("bp.in_ready", in_ready, 0);
            check("bp.held_result", out_result, 256);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_out("bp.second", r, ovf, cyc);
        check("bp.second", r, 512);
        wait_out("bp.third", r, ovf, cyc);
        check("bp.third", r, 768);
        @(negedge clk);
        check("bp.no_dup", out_valid, 0);

        // four lanes: single beat, then reset in the middle of a 3-beat vector
        push4(256, 256, 1'b1);
        in_valid4 = 1'b0;
        wait_out4("l4.single", r);
        check("l4.single", r, 1024);
        push4(256, 256, 1'b0);
        push4(256, 256, 1'b0);
        in_valid4 = 1'b0;
        #1 rst4 = 1'b1;
        #1;
        check("l4.rst.out_result", out_result4, 0);
        check("l4.rst.out_valid", out_valid4, 0);
        check("l4.rst.in_ready", in_ready4, 1);
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        push4(256, 256, 1'b0);
        push4(512, 256, 1'b1);
        in_valid4 = 1'b0;
        wait_out4("l4.after_rst", r);
        check("l4.after_rst", r, 3072);
        check("l4.after_rst.overflow", out_overflow4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
